counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
Receive-side monitor for the board counter's output bus. It samples counter_value_i together with the same enable that drives the counter and predicts every next value. It acquires lock, then flags, counts and latches any deviation; it also counts wrap-arounds. It sits on the board top beside the counter as a self-check and debug observer and never drives the counter.

Parameters:
WIDTH, 4, width of observed counter value
LOCK_CYCLES, 4, consecutive correct predictions required to assert lock (1..255)
ERR_CNT_WIDTH, 8, width of saturating error counter
WRAP_CNT_WIDTH, 16, width of wrap counter (wraps modulo 2^WRAP_CNT_WIDTH)

Ports:
clock_i  input  1  single system clock; all logic on rising edge
reset_n_i  input  1  synchronous, active-low reset
enable_i  input  1  same enable that drives the counter; counter increments at an edge where enable_i=1
counter_value_i  input  WIDTH  observed counter output
clear_i  input  1  synchronous clear of counters, sticky flag and lock; equivalent to reset for this block
locked_o  output  1  high while in LOCKED
error_o  output  1  one-cycle pulse per detected mismatch while LOCKED
error_sticky_o  output  1  set on any error; cleared only by reset/clear_i
error_count_o  output  ERR_CNT_WIDTH  saturating count of errors
wrap_count_o  output  WRAP_CNT_WIDTH  count of correct max->0 transitions while LOCKED

Behaviour:
- Reset (reset_n_i=0 at an edge) or clear_i=1 at an edge: state=UNSYNC; match_cnt=0; all outputs 0; prev registers are don't-care. reset_n_i has priority over clear_i.
- Every edge outside reset/clear: prev_val<=counter_value_i; prev_en<=enable_i. This runs in all states, so re-baselining is automatic.
- Expected value: exp = prev_en ? (prev_val+1) mod 2^WIDTH : prev_val. Compare at each edge: match = (counter_value_i==exp).
- UNSYNC: capture only; no compare. Next state is ACQUIRE.
- ACQUIRE on match: match_cnt++. When match_cnt reaches LOCK_CYCLES, go LOCKED and zero match_cnt.
- ACQUIRE on mismatch: match_cnt=0; stay in ACQUIRE; no error reported.
- LOCKED on match: stay. If prev_en=1 and prev_val=2^WIDTH-1 (correct wrap to 0), wrap_count_o++ modulo 2^WRAP_CNT_WIDTH.
- LOCKED on mismatch: error_o=1 for exactly the next cycle; error_sticky_o=1; error_count_o++ saturating at all-ones; go FAULT.
- FAULT: lasts one cycle with locked_o=0, then goes to ACQUIRE with match_cnt=0. No compare is made in FAULT. The sample taken in FAULT becomes the new baseline.
- All outputs are registered. locked_o and error_o change in the cycle after the deciding edge. Minimum lock latency from reset release is 1+LOCK_CYCLES edges.
- Mismatch caused by a counter reset to 0 while LOCKED counts as one error, then re-acquires.
- clear_i mid-LOCKED: drops lock immediately at that edge and zeros counters; no error pulse.
- Simultaneous clear_i and mismatch: clear wins; no error recorded.
- Width rules: all comparisons and increments are modulo 2^WIDTH; no X propagation from prev registers. Compare is gated off in UNSYNC/FAULT.

Test Plan:
- Reset, then enable_i=1 with the counter driven 0,1,2,...: locked_o rises after 5 edges (LOCK_CYCLES=4); error_count_o=0; error_sticky_o=0.
- Locked, free-run 40 increments from 0: wrap_count_o=2 (15->0 twice); no errors.
- Locked, enable_i toggled 1,0,0,1 with the value holding correctly: no error; locked_o stays 1.
- Locked, inject 5->7 instead of 5->6: error_o pulses for one cycle; error_count_o=1; sticky=1; locked_o drops for FAULT then ACQUIRE; re-locks after 4 correct steps; sticky remains 1.
- Inject 300 mismatches with ERR_CNT_WIDTH=8 (re-lock between each): error_count_o saturates at 255.
- Assert clear_i while locked, coincident with a mismatch: all outputs 0 next cycle; no error pulse; re-lock takes 5 edges. Repeat with reset_n_i to show identical behaviour.

Source files
------------

// File: rtl/counter_checker.sv
// Receive-side observer for a free-running up-counter: predicts each next value
// from the previous sample and enable, locks, then flags/counts deviations and wraps.
module counter_checker #(
  parameter int WIDTH          = 4,
  parameter int LOCK_CYCLES    = 4,
  parameter int ERR_CNT_WIDTH  = 8,
  parameter int WRAP_CNT_WIDTH = 16
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic                      enable_i,
  input  logic [WIDTH-1:0]          counter_value_i,
  input  logic                      clear_i,
  output logic                      locked_o,
  output logic                      error_o,
  output logic                      error_sticky_o,
  output logic [ERR_CNT_WIDTH-1:0]  error_count_o,
  output logic [WRAP_CNT_WIDTH-1:0] wrap_count_o
);

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]         VAL_MAX   = {WIDTH{1'b1}};
  localparam logic [7:0]               LOCK_LAST = 8'(LOCK_CYCLES - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX   = {ERR_CNT_WIDTH{1'b1}};

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    if (v == ERR_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ERR_CNT_WIDTH'(1);
    end
  endfunction

  state_t                    state_q,     state_d;
  logic [7:0]                match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0]          prev_val_q;
  logic                      prev_en_q;
  logic                      locked_q,    locked_d;
  logic                      error_q,     error_d;
  logic                      sticky_q,    sticky_d;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q,   err_cnt_d;
  logic [WRAP_CNT_WIDTH-1:0] wrap_cnt_q,  wrap_cnt_d;

  logic [WIDTH-1:0]          exp_val_s;
  logic                      match_s;
  logic                      wrap_s;

  // Prediction from the previous sample; prev registers are reset so no X leaks in.
  always_comb begin
    if (prev_en_q) begin
      exp_val_s = prev_val_q + WIDTH'(1);
    end else begin
      exp_val_s = prev_val_q;
    end
    match_s = (counter_value_i == exp_val_s);
    wrap_s  = prev_en_q && (prev_val_q == VAL_MAX);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    error_d     = 1'b0;
    sticky_d    = sticky_q;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    case (state_q)
      ST_UNSYNC: begin
        state_d     = ST_ACQUIRE;
        match_cnt_d = 8'd0;
      end
      ST_ACQUIRE: begin
        if (!match_s) begin
          match_cnt_d = 8'd0;
        end else if (match_cnt_q == LOCK_LAST) begin
          state_d     = ST_LOCKED;
          match_cnt_d = 8'd0;
        end else begin
          match_cnt_d = match_cnt_q + 8'd1;
        end
      end
      ST_LOCKED: begin
        if (!match_s) begin
          state_d   = ST_FAULT;
          error_d   = 1'b1;
          sticky_d  = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
        end else if (wrap_s) begin
          wrap_cnt_d = wrap_cnt_q + WRAP_CNT_WIDTH'(1);
        end else begin
          wrap_cnt_d = wrap_cnt_q;
        end
      end
      ST_FAULT: begin
        // This edge's sample is captured below as the new baseline.
        state_d     = ST_ACQUIRE;
        match_cnt_d = 8'd0;
      end
      default: begin
        state_d     = ST_UNSYNC;
        match_cnt_d = 8'd0;
      end
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  // State, sample and output registers; reset has priority over clear.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i || clear_i) begin
      state_q     <= ST_UNSYNC;
      match_cnt_q <= 8'd0;
      prev_val_q  <= '0;
      prev_en_q   <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      sticky_q    <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      prev_val_q  <= counter_value_i;
      prev_en_q   <= enable_i;
      locked_q    <= locked_d;
      error_q     <= error_d;
      sticky_q    <= sticky_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign locked_o       = locked_q;
  assign error_o        = error_q;
  assign error_sticky_o = sticky_q;
  assign error_count_o  = err_cnt_q;
  assign wrap_count_o   = wrap_cnt_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: expected outputs are queued per edge and
// compared against the DUT one time unit after that edge.
module tb_counter_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  cval;
  logic        clear;
  logic        locked;
  logic        error;
  logic        sticky;
  logic [7:0]  err_cnt;
  logic [15:0] wrap_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        l;
    logic        e;
    logic        s;
    logic [7:0]  ec;
    logic [15:0] wc;
  } exp_t;

  exp_t sb_q[$];

  logic        exp_s;
  logic [7:0]  exp_ec;
  logic [15:0] exp_wc;
  logic [3:0]  cv;

  counter_checker #(
    .WIDTH(4), .LOCK_CYCLES(4), .ERR_CNT_WIDTH(8), .WRAP_CNT_WIDTH(16)
  ) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .enable_i       (enable),
    .counter_value_i(cval),
    .clear_i        (clear),
    .locked_o       (locked),
    .error_o        (error),
    .error_sticky_o (sticky),
    .error_count_o  (err_cnt),
    .wrap_count_o   (wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One edge: queue the expectation, drive, clock, pop and compare.
  task automatic step(input logic en, input logic [3:0] val, input logic clr, input logic rn,
                      input logic el, input logic ee, input string tag);
    exp_t x;
    x.l = el; x.e = ee; x.s = exp_s; x.ec = exp_ec; x.wc = exp_wc;
    sb_q.push_back(x);
    enable = en; cval = val; clear = clr; rst_n = rn;
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk({tag, ".locked"},  {31'd0, locked},   {31'd0, x.l});
    chk({tag, ".error"},   {31'd0, error},    {31'd0, x.e});
    chk({tag, ".sticky"},  {31'd0, sticky},   {31'd0, x.s});
    chk({tag, ".err_cnt"}, {24'd0, err_cnt},  {24'd0, x.ec});
    chk({tag, ".wrap_cnt"},{16'd0, wrap_cnt}, {16'd0, x.wc});
  endtask

  // Five correctly incrementing samples from start: locks on the fifth edge.
  task automatic acquire(input logic [3:0] start, input string tag);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, start + 4'(i), 1'b0, 1'b1, (i == 4), 1'b0, tag);
    end
    cv = start + 4'd4;
  endtask

  task automatic inject_mismatch(input string tag);
    exp_s = 1'b1;
    if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
    step(1'b1, cv + 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, {tag, ".mis"});
    cv = cv + 4'd3;
    step(1'b1, cv, 1'b0, 1'b1, 1'b0, 1'b0, {tag, ".fault"});
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, cv + 4'(i), 1'b0, 1'b1, (i == 4), 1'b0, {tag, ".relock"});
    end
    cv = cv + 4'd4;
  endtask

  initial begin
    exp_s = 1'b0; exp_ec = 8'd0; exp_wc = 16'd0; cv = 4'd0;
    enable = 1'b0; cval = 4'd0; clear = 1'b0; rst_n = 1'b0;

    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");

    // Lock ending on 0 so the free run below starts from 0.
    acquire(4'd12, "lock");

    for (int i = 1; i <= 40; i++) begin
      if (4'(i) == 4'd0) exp_wc = exp_wc + 16'd1;
      step(1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b0, "freerun");
    end
    chk("freerun.wraps", {16'd0, wrap_cnt}, 32'd2);
    cv = 4'd8;

    // Enable pattern 1,0,0,1 with the value following it.
    step(1'b1, 4'd9,  1'b0, 1'b1, 1'b1, 1'b0, "enpat");
    step(1'b0, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0, "enpat");
    step(1'b0, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0, "enpat");
    step(1'b1, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0, "enpat");
    step(1'b1, 4'd11, 1'b0, 1'b1, 1'b1, 1'b0, "enpat");
    cv = 4'd11;

    // Run up to 5 (through one more wrap), then 5->7.
    for (int i = 1; i <= 10; i++) begin
      cv = cv + 4'd1;
      if (cv == 4'd0) exp_wc = exp_wc + 16'd1;
      step(1'b1, cv, 1'b0, 1'b1, 1'b1, 1'b0, "to5");
    end
    inject_mismatch("inj57");
    chk("inj57.count", {24'd0, err_cnt}, 32'd1);

    for (int n = 0; n < 300; n++) begin
      inject_mismatch("sat");
    end
    chk("sat.count", {24'd0, err_cnt}, 32'd255);
    chk("sat.wraps", {16'd0, wrap_cnt}, 32'd3);

    // Clear coincident with a mismatch: everything zero, no error pulse.
    exp_s = 1'b0; exp_ec = 8'd0; exp_wc = 16'd0;
    step(1'b1, cv + 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, "clear");
    acquire(4'd3, "clr_relock");

    inject_mismatch("pre_rst");
    exp_s = 1'b0; exp_ec = 8'd0; exp_wc = 16'd0;
    step(1'b1, cv + 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, "rstmis");
    acquire(4'd3, "rst_relock");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
